// File: rtl/dspace_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// dspace_frame_tx_pkg
// Shared definitions for the dSPACE frame serialiser:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - default sync words and slot periods
//   - nibble_sel(): pick payload nibble k out of the channel shadow register
// Optional feature macro used by the importers: DSPACE_FRAME_CHK_EN
// -----------------------------------------------------------------------------
package dspace_frame_tx_pkg;

   // FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SYNC  = 3'd1;
   localparam state_t ST_PAY   = 3'd2;
   localparam state_t ST_CHK   = 3'd3;
   localparam state_t ST_TAIL1 = 3'd4;
   localparam state_t ST_TAIL2 = 3'd5;

   // Default frame delimiters
   localparam logic [3:0] DEF_SYNC_W = 4'h0;
   localparam logic [3:0] DEF_SYNC_F = 4'hF;

   // Default slot periods in clk cycles, indexed by sw
   localparam int DEF_RATE0 = 500;
   localparam int DEF_RATE1 = 750;
   localparam int DEF_RATE2 = 1000;
   localparam int DEF_RATE3 = 1250;

   // Widest shadow register / bus word the helper can handle
   localparam int SHADOW_MAX = 512;
   localparam int NIB_MAX    = 16;

   // Return the k-th nw-bit group of the (zero-extended) shadow register,
   // least-significant group first. The caller truncates to its bus width.
   function automatic logic [NIB_MAX-1:0] nibble_sel(
      input logic [SHADOW_MAX-1:0] shadow,
      input int unsigned           k,
      input int unsigned           nw
   );
      logic [SHADOW_MAX-1:0] w_shifted;
      w_shifted = shadow >> (k * nw);
      return w_shifted[NIB_MAX-1:0];
   endfunction

endpackage

// File: rtl/dspace_slot_timer.sv
// -----------------------------------------------------------------------------
// dspace_slot_timer
// Slot timing for the dSPACE frame serialiser: latches the slot period P from
// sw at frame start, runs the slot counter 0..P-1, flags the last cycle of a
// slot (tick) and produces the registered frate strobe (high while cnt < P/2).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_load     a new frame starts on this edge (latch P, restart counter)
//   i_stop     the frame ends on this edge and the block goes idle
//   i_active   a frame is in progress (FSM not idle)
//   i_sw       rate select, sampled only with i_load
//   o_tick     combinational: current cycle is the last of the slot
//   o_frate    registered slot strobe
// -----------------------------------------------------------------------------
module dspace_slot_timer #(
   parameter int RW    = 11,
   parameter int RATE0 = 500,
   parameter int RATE1 = 750,
   parameter int RATE2 = 1000,
   parameter int RATE3 = 1250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic       i_stop,
   input  logic       i_active,
   input  logic [1:0] i_sw,
   output logic       o_tick,
   output logic       o_frate
);

   logic [RW-1:0] r_period;
   logic [RW-1:0] r_cnt;
   logic          r_frate;
   logic [RW-1:0] w_rate_sel;
   logic [RW-1:0] w_cnt_nxt;
   logic [RW-1:0] w_half;
   logic          w_frate_nxt;

   // Decode rate select into a period
   always_comb begin
      w_rate_sel = RW'(RATE0);
      case (i_sw)
         2'd0:    w_rate_sel = RW'(RATE0);
         2'd1:    w_rate_sel = RW'(RATE1);
         2'd2:    w_rate_sel = RW'(RATE2);
         2'd3:    w_rate_sel = RW'(RATE3);
         default: w_rate_sel = RW'(RATE0);
      endcase
   end

   assign w_half = r_period >> 1;
   assign o_tick = i_active && (r_cnt == (r_period - RW'(1)));

   // Next counter value and next strobe level. On load the counter restarts at
   // 0, where frate is always high for any legal period, so the stale half of
   // the previous period never matters.
   always_comb begin
      w_cnt_nxt   = RW'(0);
      w_frate_nxt = 1'b0;
      if (i_load || o_tick || !i_active) begin
         w_cnt_nxt = RW'(0);
      end else begin
         w_cnt_nxt = r_cnt + RW'(1);
      end
      if (i_load) begin
         w_frate_nxt = 1'b1;
      end else if (!i_active || i_stop) begin
         w_frate_nxt = 1'b0;
      end else begin
         w_frate_nxt = (w_cnt_nxt < w_half);
      end
   end

   // Period latch, slot counter and strobe register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period <= RW'(RATE0);
         r_cnt    <= RW'(0);
         r_frate  <= 1'b0;
      end else begin
         if (i_load) begin
            r_period <= w_rate_sel;
         end else begin
            r_period <= r_period;
         end
         r_cnt   <= w_cnt_nxt;
         r_frate <= w_frate_nxt;
      end
   end

   assign o_frate = r_frate;

endmodule

// File: rtl/dspace_frame_tx.sv
// -----------------------------------------------------------------------------
// dspace_frame_tx
// Master-side frame serialiser to the dSPACE board. Each frame is
//   SYNC_W, PAY[0..NP-1] (NP = NCH*DW/NW, LS nibble of channel 0 first),
//   optional CHK, SYNC_F, SYNC_F
// with every slot lasting P clk cycles; P is chosen by sw at frame start.
// ch_data and sw are snapshotted on SYNC entry. Dropping en lets the current
// frame finish; frames run back to back while en stays high.
// Optional feature: define DSPACE_FRAME_CHK_EN to insert a checksum slot that
// makes payload + checksum sum to 0 mod 2^NW.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             start / continue framing
//   sw[1:0]        rate select
//   ch_data        NCH*DW channel words, channel 0 in the low DW bits
//   dspace_upper   registered slot word to dSPACE
//   frate          registered slot strobe, high for the first half of a slot
//   frame_start    one-cycle pulse as the SYNC slot begins
//   fin            one-cycle pulse as the first SYNC_F slot begins
// Limits: NCH*DW <= 512, NW <= 16.
// -----------------------------------------------------------------------------
module dspace_frame_tx
   import dspace_frame_tx_pkg::*;
#(
   parameter int            NCH    = 6,
   parameter int            DW     = 8,
   parameter int            NW     = 4,
   parameter int            RW     = 11,
   parameter int            RATE0  = DEF_RATE0,
   parameter int            RATE1  = DEF_RATE1,
   parameter int            RATE2  = DEF_RATE2,
   parameter int            RATE3  = DEF_RATE3,
   parameter logic [NW-1:0] SYNC_W = NW'(DEF_SYNC_W),
   parameter logic [NW-1:0] SYNC_F = NW'(DEF_SYNC_F)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        sw,
   input  logic [NCH*DW-1:0] ch_data,
   output logic [NW-1:0]     dspace_upper,
   output logic              frate,
   output logic              frame_start,
   output logic              fin
);

   localparam int NP = NCH * DW / NW;
   localparam int KW = (NP > 1) ? $clog2(NP) : 1;

   state_t            r_state;
   logic [KW-1:0]     r_k;
   logic [NCH*DW-1:0] r_shadow;
   logic [NW-1:0]     r_upper;
   logic              r_fstart;
   logic              r_fin;
`ifdef DSPACE_FRAME_CHK_EN
   logic [NW-1:0]     r_acc;
`endif

   logic              w_tick;
   logic              w_start;
   logic              w_stop;
   logic              w_pay_last;
   logic              w_pay_adv;
   logic [KW-1:0]     w_k_nxt;
   logic [NW-1:0]     w_nib_nxt;

   // A frame starts from IDLE as soon as en is seen, or straight after TAIL2
   assign w_start    = ((r_state == ST_IDLE) && en) ||
                       ((r_state == ST_TAIL2) && w_tick && en);
   assign w_stop     = (r_state == ST_TAIL2) && w_tick && !en;
   assign w_pay_last = (r_k == KW'(NP - 1));
   // Edges on which a new payload nibble goes onto the bus
   assign w_pay_adv  = w_tick && ((r_state == ST_SYNC) ||
                                  ((r_state == ST_PAY) && !w_pay_last));
   assign w_k_nxt    = (r_state == ST_SYNC) ? KW'(0) : (r_k + KW'(1));
   assign w_nib_nxt  = NW'(nibble_sel(SHADOW_MAX'(r_shadow), 32'(w_k_nxt), 32'(NW)));

   dspace_slot_timer #(
      .RW    (RW),
      .RATE0 (RATE0),
      .RATE1 (RATE1),
      .RATE2 (RATE2),
      .RATE3 (RATE3)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_start),
      .i_stop   (w_stop),
      .i_active (r_state != ST_IDLE),
      .i_sw     (sw),
      .o_tick   (w_tick),
      .o_frate  (frate)
   );

`ifdef DSPACE_FRAME_CHK_EN
   // Running sum of the payload nibbles as each one enters the bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= NW'(0);
      end else if (w_start) begin
         r_acc <= NW'(0);
      end else if (w_pay_adv) begin
         r_acc <= r_acc + w_nib_nxt;
      end else begin
         r_acc <= r_acc;
      end
   end
`endif

   // Frame FSM, nibble index, shadow snapshot and registered bus outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_k      <= KW'(0);
         r_shadow <= '0;
         r_upper  <= SYNC_W;
         r_fstart <= 1'b0;
         r_fin    <= 1'b0;
      end else begin
         r_fstart <= 1'b0;
         r_fin    <= 1'b0;
         if (w_start) begin
            r_state  <= ST_SYNC;
            r_k      <= KW'(0);
            r_shadow <= ch_data;
            r_upper  <= SYNC_W;
            r_fstart <= 1'b1;
         end else if (w_pay_adv) begin
            r_state <= ST_PAY;
            r_k     <= w_k_nxt;
            r_upper <= w_nib_nxt;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_upper <= SYNC_F;
               end
               ST_PAY: begin
                  // only reached on the tick of the last payload slot
                  if (w_tick) begin
`ifdef DSPACE_FRAME_CHK_EN
                     r_state <= ST_CHK;
                     r_upper <= NW'(0) - r_acc;
`else
                     r_state <= ST_TAIL1;
                     r_upper <= SYNC_F;
                     r_fin   <= 1'b1;
`endif
                  end else begin
                     r_state <= r_state;
                  end
               end
`ifdef DSPACE_FRAME_CHK_EN
               ST_CHK: begin
                  if (w_tick) begin
                     r_state <= ST_TAIL1;
                     r_upper <= SYNC_F;
                     r_fin   <= 1'b1;
                  end else begin
                     r_state <= r_state;
                  end
               end
`endif
               ST_TAIL1: begin
                  if (w_tick) begin
                     r_state <= ST_TAIL2;
                     r_upper <= SYNC_F;
                  end else begin
                     r_state <= r_state;
                  end
               end
               ST_TAIL2: begin
                  // the en=1 case is handled by w_start above
                  if (w_stop) begin
                     r_state <= ST_IDLE;
                     r_upper <= SYNC_F;
                  end else begin
                     r_state <= r_state;
                  end
               end
               ST_SYNC: begin
                  r_state <= r_state;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_upper <= SYNC_F;
               end
            endcase
         end
      end
   end

   assign dspace_upper = r_upper;
   assign frame_start  = r_fstart;
   assign fin          = r_fin;

endmodule

// File: tb/tb_dspace_frame_tx.sv
module tb_dspace_frame_tx;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  sw;
   logic [47:0] ch_data;
   logic [3:0]  dspace_upper;
   logic        frate;
   logic        frame_start;
   logic        fin;

   int n_total;
   int n_bad;

   typedef struct {
      logic [3:0] word;
      int         len;
      bit         fs;
      bit         fn;
      bit         idle_after;
   } slot_t;

   slot_t sb[$];

   dspace_frame_tx dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sw           (sw),
      .ch_data      (ch_data),
      .dspace_upper (dspace_upper),
      .frate        (frate),
      .frame_start  (frame_start),
      .fin          (fin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected slot sequence of one frame, built from the data word directly
   task automatic push_frame(input logic [47:0] d, input int p, input bit idle_after);
      slot_t       s;
      int          sum;
      logic [47:0] t;
      s.len = p; s.idle_after = 1'b0; s.fn = 1'b0;
      s.word = 4'h0; s.fs = 1'b1;
      sb.push_back(s);
      s.fs = 1'b0; sum = 0; t = d;
      for (int k = 0; k < 12; k++) begin
         s.word = t[3:0];
         sum += int'(t[3:0]);
         t = t >> 4;
         sb.push_back(s);
      end
`ifdef DSPACE_FRAME_CHK_EN
      s.word = 4'(0 - sum);
      sb.push_back(s);
`endif
      s.word = 4'hF; s.fn = 1'b1;
      sb.push_back(s);
      s.fn = 1'b0; s.idle_after = idle_after;
      sb.push_back(s);
   endtask

   task automatic wait_pulse(input bit on_fin, input int budget);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < budget && !hit; n++) begin
         @(negedge clk);
         hit = on_fin ? fin : frame_start;
      end
      check(on_fin ? "wait_fin" : "wait_frame_start", int'(hit), 1);
   endtask

   // Monitor: every slot begins with a frate rising edge; pop the expected slot
   // there and close it at the next rise (or at the idle cycle after TAIL2).
   slot_t cur;
   bit    open;
   bit    prev_frate;
   bit    unstable;
   int    cyc;
   int    hi;

   always @(negedge clk) begin
      if (rst) begin
         open       = 1'b0;
         prev_frate = 1'b0;
      end else begin
         if (frate && !prev_frate) begin
            if (open) begin
               check("slot_len", cyc, cur.len);
               check("slot_frate_hi", hi, cur.len / 2);
               check("slot_stable", int'(unstable), 0);
            end
            if (sb.size() == 0) begin
               check("sb_has_entry", sb.size(), 1);
               open = 1'b0;
            end else begin
               cur = sb.pop_front();
               open = 1'b1; cyc = 1; hi = 1; unstable = 1'b0;
               check("slot_word", int'(dspace_upper), int'(cur.word));
               check("slot_frame_start", int'(frame_start), int'(cur.fs));
               check("slot_fin", int'(fin), int'(cur.fn));
            end
         end else if (open) begin
            if (cyc == cur.len) begin
               check("slot_end_idle", int'(cur.idle_after), 1);
               check("slot_frate_hi", hi, cur.len / 2);
               check("slot_stable", int'(unstable), 0);
               check("idle_bus", int'(dspace_upper), 15);
               check("idle_frate", int'(frate), 0);
               open = 1'b0;
            end else begin
               cyc++;
               hi += int'(frate);
               if (dspace_upper != cur.word || frame_start || fin) unstable = 1'b1;
            end
         end
         prev_frate = frate;
      end
   end

   initial begin
      n_total = 0; n_bad = 0;
      rst = 1'b1; en = 1'b0; sw = 2'd0; ch_data = 48'h0;
      repeat (3) @(negedge clk);
      check("rst_bus", int'(dspace_upper), 0);
      check("rst_frate", int'(frate), 0);
      check("rst_frame_start", int'(frame_start), 0);
      check("rst_fin", int'(fin), 0);

      // frame 1: A5 at 500-cycle slots
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_bus_after_rst", int'(dspace_upper), 15);
      check("idle_frate_after_rst", int'(frate), 0);
      ch_data = 48'h0000_0000_00A5;
      push_frame(48'h0000_0000_00A5, 500, 1'b0);
      en = 1'b1;
      @(negedge clk);
      check("start_latency_bus", int'(dspace_upper), 0);
      check("start_latency_fs", int'(frame_start), 1);

      // mid-frame sw/ch_data change only affects frame 2
      repeat (6 * 500) @(negedge clk);
      sw = 2'd3;
      ch_data = 48'h1234_5678_9ABC;
      push_frame(48'h1234_5678_9ABC, 1250, 1'b1);
      wait_pulse(1'b1, 8000);
      wait_pulse(1'b0, 2000);

      // frame 2: drop en during PAY[3], also scramble ch_data
      repeat (4 * 1250 + 10) @(negedge clk);
      en = 1'b0;
      ch_data = 48'hDEAD_BEEF_0000;
      wait_pulse(1'b1, 20000);
      repeat (2 * 1250 + 5) @(negedge clk);
      check("idle_bus_after_en_drop", int'(dspace_upper), 15);
      check("idle_frate_after_en_drop", int'(frate), 0);

      // frame 3: all channels 8'h11 at 500, en stays high
      ch_data = 48'h1111_1111_1111;
      sw = 2'd0;
      push_frame(48'h1111_1111_1111, 500, 1'b0);
      en = 1'b1;
      @(negedge clk);
      check("restart_latency_bus", int'(dspace_upper), 0);
      check("restart_latency_fs", int'(frame_start), 1);
      repeat (3 * 500) @(negedge clk);
      ch_data = 48'hFFEE_DDCC_BBAA;
      sw = 2'd2;
      push_frame(48'hFFEE_DDCC_BBAA, 1000, 1'b0);
      wait_pulse(1'b1, 8000);
      wait_pulse(1'b0, 2000);

      // frame 4: reset in the middle of the payload
      repeat (3 * 1000 + 100) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_mid_bus", int'(dspace_upper), 0);
      check("rst_mid_frate", int'(frate), 0);
      sb.delete();
      repeat (5) @(negedge clk);
      check("rst_hold_bus", int'(dspace_upper), 0);

      // frame 5: fresh frame after release with en high, at 750
      sw = 2'd1;
      ch_data = 48'h0F1E_2D3C_4B5A;
      push_frame(48'h0F1E_2D3C_4B5A, 750, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_bus", int'(dspace_upper), 0);
      check("post_rst_fs", int'(frame_start), 1);
      repeat (2) @(negedge clk);
      en = 1'b0;
      ch_data = 48'h0;
      wait_pulse(1'b1, 15000);
      repeat (2 * 750 + 5) @(negedge clk);
      check("final_idle_bus", int'(dspace_upper), 15);
      check("final_idle_frate", int'(frate), 0);
      check("sb_drained", sb.size(), 0);
      check("no_open_slot", int'(open), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
